mc_main_ctrl: RTL and testbench
===============================

# mc_main_ctrl

Multi-cycle main control FSM for the processor datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. For every state it drives the datapath enables and mux selects, and it issues the 2-bit ALU operation code consumed by the ALU control decoder: 00 selects funct-driven R-type, 01 selects add, 10 selects sub. The block sits between the instruction register opcode field, the memory interface and the datapath.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  instr[31:26] from the instruction register; sampled in DECODE.
- zero  in  1  ALU zero flag; used only in BEQ.
- mem_ready  in  1  memory completion strobe for the current read or write.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load when zero=1.
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  register write data select: 0=ALUOut, 1=MDR.
- reg_dst  out  1  destination register select: 0=rt, 1=rd.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0=PC, 1=A register.
- alu_src_b  out  2  ALU B select: 00=B, 01=4, 10=signext, 11=signext<<2.
- pc_source  out  2  PC source: 00=ALU, 01=ALUOut, 10=jump target.
- alu_op  out  2  00=R-type/funct, 01=add, 10=sub; 11 is never driven.
- illegal  out  1  sticky unsupported-opcode flag.
- state  out  4  current state, for debug.

## Operation
- Moore FSM. All outputs decode from `state` only, except the mem_ready qualification listed below.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REXE 6, RWB 7, BEQ 8, ADDIEX 9, ADDIWB 10, JMP 11, ILL 12.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=01, pc_source=00.
  - ir_write and pc_write are asserted only when mem_ready=1.
  - Transition: go to DECODE when mem_ready=1; otherwise stay.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=01 (branch target precompute).
  - Next state by opcode: 100011 or 101011 go to MEMADR; 000000 goes to REXE; 000100 goes to BEQ; 001000 goes to ADDIEX; 000010 goes to JMP; any other opcode goes to ILL.
- MEMADR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=01.
  - Next state: MEMRD if opcode=100011, else MEMWR.
- MEMRD:
  - Outputs: mem_read=1, i_or_d=1.
  - Transition: go to MEMWB on mem_ready; otherwise stay.
- MEMWB:
  - Outputs: reg_write=1, mem_to_reg=1, reg_dst=0.
  - Next state: FETCH.
- MEMWR:
  - Outputs: mem_write=1, i_or_d=1.
  - Transition: go to FETCH on mem_ready; otherwise stay.
- REXE: alu_src_a=1, alu_src_b=00, alu_op=00; next state RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0; next state FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=10, pc_write_cond=1, pc_source=01; next state FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=01; next state ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; next state FETCH.
- JMP: pc_write=1, pc_source=10; next state FETCH.
- ILL:
  - illegal=1; all enables are 0.
  - The FSM stays in ILL until rst.
- Defaults: every output not listed for a state is 0.

## Timing
- Reset:
  - rst=1 at a rising edge loads FETCH.
  - While in reset, outputs equal the FETCH decode with ir_write and pc_write still gated by mem_ready.
  - illegal clears to 0.
- Reset mid-instruction: any state, including ILL and memory wait states, goes to FETCH on the next edge. No partial writeback is issued after that edge.
- Memory handshake:
  - mem_read and mem_write are held stable until the cycle in which mem_ready=1.
  - The transaction completes in that same cycle.
  - mem_ready outside FETCH, MEMRD and MEMWR is ignored.
- Cycle counts with mem_ready tied to 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each wait cycle in a memory state adds exactly one cycle to these counts.
- opcode must be stable from DECODE through the final state of the instruction. The IR is only written in FETCH, which guarantees this.

## Configuration
- MC_MEM_WAIT_EN:
  - Defined: the mem_ready handshake behaves as described above.
  - Undefined: mem_ready is ignored and treated as 1. FETCH, MEMRD and MEMWR each last exactly one cycle, and ir_write and pc_write are unconditional in FETCH.

## Structure
- Shared package `mc_ctrl_pkg` holds:
  - state encodings;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J);
  - ALU op constants (ALUOP_FUNCT=00, ALUOP_ADD=01, ALUOP_SUB=10);
  - alu_src_b and pc_source encodings.
- Sub-module `mc_ctrl_decode` is purely combinational and maps state and mem_ready to the control word.
- The top level holds the state register, the next-state logic and the sticky illegal flag.

## Test plan
- Reset then lw (opcode 100011), mem_ready=1:
  - Visits FETCH, DECODE, MEMADR, MEMRD, MEMWB: 5 cycles.
  - alu_op sequence is 01,01,01,xx,xx; reg_write=1 and mem_to_reg=1 only in the 5th cycle.
- R-type (000000):
  - alu_op=00 in REXE.
  - reg_write=1 and reg_dst=1 in RWB; back in FETCH after 4 cycles.
- beq (000100) with zero=1:
  - In BEQ, alu_op=10, pc_write_cond=1, pc_source=01.
  - Next state FETCH after 3 cycles.
- sw (101011) with mem_ready low for 3 cycles in MEMWR:
  - mem_write=1 and i_or_d=1 are held for 4 cycles.
  - Total 7 cycles; with MC_MEM_WAIT_EN undefined, the total is 4.
- Opcode 111111:
  - DECODE goes to ILL; illegal=1 is sticky and all enables are 0.
  - rst=1 then returns to FETCH with illegal=0.
- rst asserted during MEMRD wait: FETCH on the next edge, and no reg_write is ever asserted.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle main control FSM: states, opcodes,
// ALU op codes, datapath mux selects and the packed control word.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXE   = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JMP    = 4'd11,
    S_ILL    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_FUNCT = 2'b00;
  localparam logic [1:0] ALUOP_ADD   = 2'b01;
  localparam logic [1:0] ALUOP_SUB   = 2'b10;

  localparam logic [1:0] ASB_B        = 2'b00;
  localparam logic [1:0] ASB_FOUR     = 2'b01;
  localparam logic [1:0] ASB_SEXT     = 2'b10;
  localparam logic [1:0] ASB_SEXT_SH2 = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational Moore decode of the FSM state into the datapath control word;
// mem_ready only qualifies the IR/PC loads in FETCH.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = ASB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCS_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = ASB_SEXT_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ASB_SEXT;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_REXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ASB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = ASB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCS_ALUOUT;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_JMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multi-cycle main control: state register, next-state logic, sticky illegal flag.
// MC_MEM_WAIT_EN enables the mem_ready handshake; otherwise memory states take one cycle.
module mc_main_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic       illegal,
  output logic [3:0] state
);

  logic   rdy;
  state_t cur;
  state_t dec_state;
  logic   ill_q;
  ctrl_t  ctrl;

`ifdef MC_MEM_WAIT_EN
  assign rdy = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign rdy = 1'b1;
`endif

  // Branch qualification with zero is done by the PC load logic in the datapath.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur   <= S_FETCH;
      ill_q <= 1'b0;
    end else begin
      case (cur)
        S_FETCH: if (rdy) cur <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: cur <= S_MEMADR;
            OP_RTYPE:     cur <= S_REXE;
            OP_BEQ:       cur <= S_BEQ;
            OP_ADDI:      cur <= S_ADDIEX;
            OP_J:         cur <= S_JMP;
            default: begin
              cur   <= S_ILL;
              ill_q <= 1'b1;
            end
          endcase
        end
        S_MEMADR: cur <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (rdy) cur <= S_MEMWB;
        S_MEMWR:  if (rdy) cur <= S_FETCH;
        S_REXE:   cur <= S_RWB;
        S_ADDIEX: cur <= S_ADDIWB;
        S_MEMWB, S_RWB, S_BEQ, S_ADDIWB, S_JMP: cur <= S_FETCH;
        S_ILL:    cur <= S_ILL;
        default:  cur <= S_FETCH;
      endcase
    end
  end

  // Reset forces the FETCH decode immediately, before the first edge lands.
  assign dec_state = rst ? S_FETCH : cur;

  mc_ctrl_decode u_decode (
    .state     (dec_state),
    .mem_ready (rdy),
    .ctrl      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign pc_source     = ctrl.pc_source;
  assign alu_op        = ctrl.alu_op;
  assign illegal       = ill_q & ~rst;
  assign state         = cur;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed, table-driven bench for mc_main_ctrl plus hand sequences for
// memory waits and reset mid-instruction.
module tb_mc_main_ctrl;

`ifdef MC_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b1;
  logic       mem_ready = 1'b1;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_source, alu_op;
  logic [3:0] state;

  mc_main_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_op(alu_op), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // Field order: pcw pwc iord mrd mwr irw m2r rdst rw asa asb[2] pcs[2] aop[2] ill
  localparam logic [16:0] E_FETCH  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_01_0;
  localparam logic [16:0] E_FWAIT  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_01_0;
  localparam logic [16:0] E_DECODE = 17'b0_0_0_0_0_0_0_0_0_0_11_00_01_0;
  localparam logic [16:0] E_MEMADR = 17'b0_0_0_0_0_0_0_0_0_1_10_00_01_0;
  localparam logic [16:0] E_MEMRD  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] E_MEMWB  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] E_MEMWR  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] E_REXE   = 17'b0_0_0_0_0_0_0_0_0_1_00_00_00_0;
  localparam logic [16:0] E_RWB    = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] E_BEQ    = 17'b0_1_0_0_0_0_0_0_0_1_00_01_10_0;
  localparam logic [16:0] E_ADDIEX = 17'b0_0_0_0_0_0_0_0_0_1_10_00_01_0;
  localparam logic [16:0] E_ADDIWB = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [16:0] E_JMP    = 17'b1_0_0_0_0_0_0_0_0_0_00_10_00_0;
  localparam logic [16:0] E_ILL    = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [16:0] ctl;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [16:0] act_ctl();
    return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
            mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
            alu_op, illegal};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [5:0] op, input logic [3:0] st, input logic [16:0] ctl);
    tbl.push_back('{rst: r, op: op, rdy: 1'b1, st: st, ctl: ctl});
  endtask

  // Advance to the next cycle; inputs change 1 time unit after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int  cycles, waits, mw_cnt;
  bit  iord_bad, rw_seen;

  initial begin
    // lw
    add(0, 6'b100011, 4'd0, E_FETCH);  add(0, 6'b100011, 4'd1, E_DECODE);
    add(0, 6'b100011, 4'd2, E_MEMADR); add(0, 6'b100011, 4'd3, E_MEMRD);
    add(0, 6'b100011, 4'd4, E_MEMWB);
    // R-type
    add(0, 6'b000000, 4'd0, E_FETCH);  add(0, 6'b000000, 4'd1, E_DECODE);
    add(0, 6'b000000, 4'd6, E_REXE);   add(0, 6'b000000, 4'd7, E_RWB);
    // beq
    add(0, 6'b000100, 4'd0, E_FETCH);  add(0, 6'b000100, 4'd1, E_DECODE);
    add(0, 6'b000100, 4'd8, E_BEQ);
    // addi
    add(0, 6'b001000, 4'd0, E_FETCH);  add(0, 6'b001000, 4'd1, E_DECODE);
    add(0, 6'b001000, 4'd9, E_ADDIEX); add(0, 6'b001000, 4'd10, E_ADDIWB);
    // j
    add(0, 6'b000010, 4'd0, E_FETCH);  add(0, 6'b000010, 4'd1, E_DECODE);
    add(0, 6'b000010, 4'd11, E_JMP);
    // sw, no wait
    add(0, 6'b101011, 4'd0, E_FETCH);  add(0, 6'b101011, 4'd1, E_DECODE);
    add(0, 6'b101011, 4'd2, E_MEMADR); add(0, 6'b101011, 4'd5, E_MEMWR);
    // illegal opcode: sticky until reset, reset forces FETCH decode at once
    add(0, 6'b111111, 4'd0, E_FETCH);  add(0, 6'b111111, 4'd1, E_DECODE);
    add(0, 6'b111111, 4'd12, E_ILL);   add(0, 6'b000000, 4'd12, E_ILL);
    add(1, 6'b000000, 4'd12, E_FETCH); add(0, 6'b000000, 4'd0, E_FETCH);
    add(0, 6'b000000, 4'd1, E_DECODE);

    // Reset state
    rst = 1'b1; mem_ready = 1'b1;
    next_cycle();
    @(negedge clk);
    check("reset_state", 32'(state), 32'd0);
    check("reset_ctl", 32'(act_ctl()), 32'(E_FETCH));
    next_cycle();
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; opcode = tbl[i].op; mem_ready = tbl[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].st));
      check($sformatf("vec%0d_ctl", i), 32'(act_ctl()), 32'(tbl[i].ctl));
      next_cycle();
    end
    rst = 1'b0;
    // Finish the R-type left in flight by the table
    opcode = 6'b000000;
    cycles = 0;
    while (state != 4'd0 && cycles < 10) begin next_cycle(); cycles++; end
    check("return_fetch", 32'(state), 32'd0);

    // FETCH with mem_ready low
    mem_ready = 1'b0; opcode = 6'b000010;
    @(negedge clk);
    check("fwait_ctl", 32'(act_ctl()), WAIT_EN ? 32'(E_FWAIT) : 32'(E_FETCH));
    next_cycle();
    check("fwait_state", 32'(state), WAIT_EN ? 32'd0 : 32'd1);
    mem_ready = 1'b1;
    cycles = 0;
    while (state != 4'd0 && cycles < 10) begin next_cycle(); cycles++; end
    check("fwait_recover", 32'(state), 32'd0);

    // sw with three wait cycles in MEMWR
    opcode = 6'b101011; cycles = 0; waits = 0; mw_cnt = 0; iord_bad = 0;
    do begin
      @(negedge clk);
      if (state == 4'd5 && waits < 3) begin mem_ready = 1'b0; waits++; end
      else mem_ready = 1'b1;
      #1;
      if (mem_write) begin mw_cnt++; if (!i_or_d) iord_bad = 1; end
      next_cycle();
      cycles++;
    end while (state != 4'd0 && cycles < 20);
    mem_ready = 1'b1;
    check("sw_cycles", 32'(cycles), WAIT_EN ? 32'd7 : 32'd4);
    check("sw_mw_cycles", 32'(mw_cnt), WAIT_EN ? 32'd4 : 32'd1);
    check("sw_iord_held", 32'(iord_bad), 32'd0);

    // Reset while lw waits in MEMRD
    opcode = 6'b100011; rw_seen = 0; cycles = 0;
    while (state != 4'd3 && cycles < 10) begin
      @(negedge clk); if (reg_write) rw_seen = 1;
      next_cycle(); cycles++;
    end
    check("memrd_reached", 32'(state), 32'd3);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    if (reg_write) rw_seen = 1;
    check("memrd_ctl", 32'(act_ctl()), 32'(E_MEMRD));
    if (WAIT_EN) begin
      next_cycle();
      check("memrd_wait_state", 32'(state), 32'd3);
      @(negedge clk); #1;
      if (reg_write) rw_seen = 1;
    end
    rst = 1'b1;
    #1;
    if (reg_write) rw_seen = 1;
    next_cycle();
    check("memrd_rst_state", 32'(state), 32'd0);
    rst = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    if (reg_write) rw_seen = 1;
    check("memrd_rst_fetch_ctl", 32'(act_ctl()), 32'(E_FETCH));
    check("memrd_no_reg_write", 32'(rw_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
